imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Synthesizable boot loader that streams a program image into the MIPS16 instruction memory over a valid/ready handshake, then sequences the core out of reset. It replaces file-based memory preload and a free-running clock enable with a real hardware path. It is parametrised in instruction width, memory depth and reset-hold length, and optionally verifies an image checksum before releasing the core. It sits between the image source (testbench driver or a UART front end) and `mips_16_core_top`.

## Interface
- `INST_W`, 16, instruction word width.
- `DEPTH`, 256, instruction memory depth in words; must be ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`, imem address width.
- `RST_HOLD`, 4, cycles the core is clocked while held in reset; must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset; **asynchronous and active-high**.
- `start` in 1: single-cycle pulse that begins a load.
- `in_valid` in 1: an image word is present.
- `in_ready` out 1: the loader accepts a word.
- `in_data` in INST_W: image word.
- `in_last` in 1: marks the final word of the image.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out INST_W: write data.
- `core_rst` out 1: core reset, active-high.
- `core_clk_en` out 1: core clock enable.
- `busy` out 1: a load or reset hold is in progress.
- `done` out 1: the core is running a loaded image.
- `error` out 1: the load failed (overflow or checksum).
- `word_count` out ADDR_W+1: number of words written in the current or last load.

## Operation
- States: IDLE, LOAD, HOLD, RUN, ERROR. The `boot_state_t` state register is exposed for debug.
- **Reset:** state = IDLE. `in_ready`, `imem_we`, `core_clk_en`, `busy`, `done`, `error` are 0. `imem_addr`, `imem_wdata`, `word_count` are 0. `core_rst` = 1.
- **IDLE:** on `start`, go to LOAD and clear the counters.
- **Start from RUN or ERROR:** the same transition applies. `core_rst` reasserts and `core_clk_en`, `done`, `error` clear on the next edge.
- **Start in LOAD or HOLD:** ignored.
- **LOAD:** `in_ready` = 1 and `busy` = 1. A word is accepted when `in_valid && in_ready`.
- **Accepted data word:** written to address `word_count`, then `word_count` increments.
- **Accepted word with `in_last`:** the load ends; go to HOLD.
- **Overflow:** if `word_count` reaches DEPTH without `in_last`, `in_ready` drops and the state goes to ERROR. The DEPTH-th word is still written.
- **HOLD:** `core_rst` = 1 and `core_clk_en` = 1 for exactly RST_HOLD cycles, then go to RUN.
- **RUN:** `core_rst` = 0, `core_clk_en` = 1, `done` = 1, `busy` = 0.
- **ERROR:** `error` = 1, `core_rst` = 1, `core_clk_en` = 0. The state is left only via `start` or `rst`.
- **Address arithmetic:** unsigned. `imem_addr` never wraps; overflow is an error, not a wrap.
- **`rst` mid-load:** returns to IDLE immediately. Memory contents are undefined.

## Timing
- Every output is registered.
- The write strobe follows acceptance by one cycle: a word accepted at edge n gives `imem_we` = 1 with address and data valid during cycle n+1. `imem_we` is a single cycle per word.
- Sustained throughput is one word per cycle with `in_valid` held high.
- `in_ready` falls in the cycle after the `in_last` handshake.
- `word_count` updates on the same edge as `imem_we` assertion.
- Latency from `in_last` acceptance to `core_rst` = 0 is 1 + RST_HOLD cycles.

## Configuration
- Macro: `BOOT_CHECKSUM_EN`.
- **Defined:** the word carrying `in_last` is a checksum and is not written to memory.
  - The loader accumulates the sum of all data words modulo 2^INST_W.
  - On match, go to HOLD; on mismatch, go to ERROR.
  - An image of only the checksum word (value 0) is legal and gives `word_count` = 0.
- **Undefined:** the `in_last` word is an ordinary data word. No checksum logic is built.

## Structure
- `MIPS_pkg` holds `boot_state_t`, the default `INST_W`, and `BOOT_RST_HOLD_DEFAULT`.
- One sub-module, `boot_checksum`, holds the accumulator: clear, add on accept, compare. It is instantiated only under `BOOT_CHECKSUM_EN`.

## Test plan
- **Reset values:** `rst` high for 3 cycles. Expect `core_rst` = 1, all other outputs 0, `in_ready` = 0 while `in_valid` = 1.
- **Basic load, macro off:** `start`, then words 0x1111, 0x2222, 0x3333 (last), back to back. Expect writes at addresses 0–2 on consecutive cycles, `word_count` = 3, and `core_rst` falling exactly 5 cycles after the last handshake with RST_HOLD = 4.
- **Overflow:** DEPTH = 4, five words sent with no `in_last`. Expect 4 writes, `in_ready` low, `error` = 1, `core_clk_en` = 0.
- **Checksum pass/fail, macro on:** data 0x0001, 0xFFFF, then checksum 0x0000 gives RUN with `word_count` = 2. Repeating with checksum 0x0001 gives ERROR.
- **Reset mid-load:** `rst` asserted after 2 of 5 words. Expect IDLE, `word_count` = 0, `core_rst` = 1; a new `start` and full reload reaches RUN.
- **Restart and ignore:** `start` during RUN reasserts `core_rst` next cycle and reloads. `start` pulsed during LOAD has no effect.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and defaults for the MIPS16 instruction-memory boot loader.
package MIPS_pkg;

    localparam int INST_W_DEFAULT        = 16;
    localparam int BOOT_RST_HOLD_DEFAULT = 4;

    typedef enum logic [2:0] {
        BOOT_IDLE  = 3'd0,
        BOOT_LOAD  = 3'd1,
        BOOT_HOLD  = 3'd2,
        BOOT_RUN   = 3'd3,
        BOOT_ERROR = 3'd4
    } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Image stream (valid/ready) and instruction-memory write bus of the boot loader.
// slave: the loader side. master: image source / memory side.
interface imem_boot_loader_if #(
    parameter int INST_W = 16,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_data;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_checksum.sv
// Image checksum accumulator: sum of data words modulo 2^INST_W,
// compared against the incoming checksum word.
module boot_checksum #(
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [INST_W-1:0] data,
    output logic              match
);
    logic [INST_W-1:0] sum_r;

    // Accumulate accepted data words; cleared at the start of every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= {INST_W{1'b0}};
        end else if (clr) begin
            sum_r <= {INST_W{1'b0}};
        end else if (add) begin
            sum_r <= sum_r + data;
        end
    end

    assign match = (sum_r == data);
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams an image into the instruction memory, then holds the
// core in reset for RST_HOLD clocked cycles before releasing it.
// Optional feature macro: BOOT_CHECKSUM_EN (in_last word is a checksum).
module imem_boot_loader
    import MIPS_pkg::*;
#(
    parameter int INST_W   = INST_W_DEFAULT,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RST_HOLD = BOOT_RST_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                core_rst,
    output logic                core_clk_en,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     word_count,
    output boot_state_t         state
);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    boot_state_t       state_r;
    boot_state_t       state_nxt_s;
    logic              in_ready_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [INST_W-1:0] imem_wdata_r;
    logic [ADDR_W:0]   word_count_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              core_rst_r;
    logic              core_clk_en_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    logic              accept_s;
    logic              last_s;
    logic              write_s;
    logic              full_s;
    logic              overflow_s;
    logic              image_ok_s;
    logic              load_start_s;

    assign accept_s     = bus.in_valid && in_ready_r;
    assign last_s       = accept_s && bus.in_last;
    // The word written now lands at the last memory location.
    assign full_s       = (word_count_r == (ADDR_W + 1)'(DEPTH - 1));
    assign overflow_s   = write_s && !bus.in_last && full_s;
    assign load_start_s = (state_r != BOOT_LOAD) && (state_nxt_s == BOOT_LOAD);

`ifdef BOOT_CHECKSUM_EN
    // The closing word carries the checksum and is never stored.
    assign write_s = accept_s && !bus.in_last;

    boot_checksum #(.INST_W(INST_W)) u_checksum (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_start_s),
        .add   (write_s),
        .data  (bus.in_data),
        .match (image_ok_s)
    );
`else
    assign write_s    = accept_s;
    assign image_ok_s = 1'b1;
`endif

    // Next-state decision for the boot sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT_IDLE: begin
                if (start) state_nxt_s = BOOT_LOAD;
                else       state_nxt_s = BOOT_IDLE;
            end
            BOOT_LOAD: begin
                if (last_s)          state_nxt_s = image_ok_s ? BOOT_HOLD : BOOT_ERROR;
                else if (overflow_s) state_nxt_s = BOOT_ERROR;
                else                 state_nxt_s = BOOT_LOAD;
            end
            BOOT_HOLD: begin
                if (hold_cnt_r == HOLD_W'(RST_HOLD)) state_nxt_s = BOOT_RUN;
                else                                 state_nxt_s = BOOT_HOLD;
            end
            BOOT_RUN: begin
                if (start) state_nxt_s = BOOT_LOAD;
                else       state_nxt_s = BOOT_RUN;
            end
            BOOT_ERROR: begin
                if (start) state_nxt_s = BOOT_LOAD;
                else       state_nxt_s = BOOT_ERROR;
            end
            default: state_nxt_s = BOOT_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= BOOT_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            core_rst_r    <= 1'b1;
            core_clk_en_r <= 1'b0;
        end else begin
            in_ready_r    <= (state_nxt_s == BOOT_LOAD);
            busy_r        <= (state_nxt_s == BOOT_LOAD) || (state_nxt_s == BOOT_HOLD);
            done_r        <= (state_nxt_s == BOOT_RUN);
            error_r       <= (state_nxt_s == BOOT_ERROR);
            core_rst_r    <= (state_nxt_s != BOOT_RUN);
            // The first HOLD cycle is left unclocked so the final write settles.
            core_clk_en_r <= (state_nxt_s == BOOT_RUN) || (state_r == BOOT_HOLD);
        end
    end

    // Memory write port and word counter; a write lands one cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= {INST_W{1'b0}};
            word_count_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            imem_we_r <= write_s;
            if (load_start_s) begin
                word_count_r <= {(ADDR_W + 1){1'b0}};
            end else if (write_s) begin
                imem_addr_r  <= word_count_r[ADDR_W-1:0];
                imem_wdata_r <= bus.in_data;
                word_count_r <= word_count_r + (ADDR_W + 1)'(1);
            end
        end
    end

    // Reset-hold cycle counter, running only while in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     hold_cnt_r <= {HOLD_W{1'b0}};
        else if (state_r == BOOT_HOLD) hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        else                         hold_cnt_r <= {HOLD_W{1'b0}};
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign core_rst       = core_rst_r;
    assign core_clk_en    = core_clk_en_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign word_count     = word_count_r;
    assign state          = state_r;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
module tb_imem_boot_loader;
    import MIPS_pkg::*;

    localparam int INST_W   = 16;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;
    localparam int RST_HOLD = 4;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            core_rst, core_clk_en, busy, done, error;
    logic [ADDR_W:0] word_count;
    boot_state_t     state;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  exp_wc = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    imem_boot_loader_if #(.INST_W(INST_W), .ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.INST_W(INST_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .core_rst    (core_rst),
        .core_clk_en (core_clk_en),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .word_count  (word_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are {in_ready, core_rst, core_clk_en, busy, done, error}.
    task automatic status(input string name, input logic [5:0] flags, input int wc, input boot_state_t st);
        check({name, "_flags"}, {26'd0, bus.in_ready, core_rst, core_clk_en, busy, done, error}, {26'd0, flags});
        check({name, "_wc"}, 32'(word_count), 32'(wc));
        check({name, "_state"}, 32'(state), 32'(st));
    endtask

    // Drive one word at a negedge; the bench decides whether it must be accepted.
    task automatic send(input logic [INST_W-1:0] d, input logic last, input logic exp_acc);
        wr_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        check("in_ready", 32'(bus.in_ready), 32'(exp_acc));
        if (exp_acc && !(last && CS_EN)) begin
            e.cyc  = cyc + 1;
            e.addr = ADDR_W'(exp_wc);
            e.data = d;
            exp_q.push_back(e);
            exp_wc++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_wc = 0;
    endtask

    // Called on the negedge right after the closing handshake.
    task automatic wait_run(input string name);
        int n = 0;
        int h = 0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        while (core_rst && n < 20) begin
            if (core_clk_en) h++;
            @(negedge clk);
            n++;
        end
        check({name, "_rst_latency"}, 32'(n), 32'(1 + RST_HOLD));
        check({name, "_hold_clk"}, 32'(h), 32'(RST_HOLD));
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.imem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_write: addr 0x%0h data 0x%0h with none expected", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h cyc %0d expected addr 0x%0h data 0x%0h cyc %0d",
                             bus.imem_addr, bus.imem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5A5A;
        bus.in_last  = 1'b0;

        // Reset values with in_valid high.
        repeat (3) @(negedge clk);
        status("reset", 6'b010000, 0, BOOT_IDLE);
        check("reset_bus", {13'd0, bus.imem_we, bus.imem_addr, bus.imem_wdata}, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        status("idle", 6'b010000, 0, BOOT_IDLE);

        // Basic load, three words back to back.
        pulse_start();
        status("load", 6'b110100, 0, BOOT_LOAD);
        send(16'h1111, 1'b0, 1'b1);
        send(16'h2222, 1'b0, 1'b1);
        send(16'h3333, 1'b1, 1'b1);
        wait_run("basic");
        status("basic_run", 6'b001010, CS_EN ? 2 : 3, BOOT_RUN);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // Checksum pass, fail and checksum-only image.
        pulse_start();
        send(16'h0001, 1'b0, 1'b1);
        send(16'hFFFF, 1'b0, 1'b1);
        send(16'h0000, 1'b1, 1'b1);
        wait_run("cs_pass");
        status("cs_pass_run", 6'b001010, 2, BOOT_RUN);
        pulse_start();
        send(16'h0001, 1'b0, 1'b1);
        send(16'hFFFF, 1'b0, 1'b1);
        send(16'h0001, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        status("cs_fail", 6'b010001, 2, BOOT_ERROR);
        pulse_start();
        send(16'h0000, 1'b1, 1'b1);
        wait_run("cs_only");
        status("cs_only_run", 6'b001010, 0, BOOT_RUN);
        check("cs_drained", 32'(exp_q.size()), 32'd0);
`endif

        // Restart from RUN, then a start pulse during LOAD must be ignored.
        pulse_start();
        status("restart", 6'b110100, 0, BOOT_LOAD);
        send(16'h00AA, 1'b0, 1'b1);
        start = 1'b1;
        send(CS_EN ? 16'h00AA : 16'h0BBB, 1'b1, 1'b1);
        start = 1'b0;
        wait_run("ignore");
        status("ignore_run", 6'b001010, CS_EN ? 1 : 2, BOOT_RUN);
        check("ignore_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: five words without in_last into a four-word memory.
        pulse_start();
        for (int i = 0; i < 5; i++) send(16'h0A00 + 16'(i), 1'b0, i < DEPTH);
        bus.in_valid = 1'b0;
        status("overflow", 6'b010001, DEPTH, BOOT_ERROR);
        @(negedge clk);
        status("overflow_stay", 6'b010001, DEPTH, BOOT_ERROR);
        check("overflow_drained", 32'(exp_q.size()), 32'd0);

        // Start from ERROR, then reset after two words of a five-word image.
        pulse_start();
        status("err_restart", 6'b110100, 0, BOOT_LOAD);
        send(16'h0B01, 1'b0, 1'b1);
        send(16'h0B02, 1'b0, 1'b1);
        bus.in_data = 16'h0B03;
        #2 rst = 1'b1;
        @(negedge clk);
        status("midload_rst", 6'b010000, 0, BOOT_IDLE);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        status("midload_idle", 6'b010000, 0, BOOT_IDLE);
        check("midload_drained", 32'(exp_q.size()), 32'd0);

        // Full reload; the closing word lands exactly at the last location.
        pulse_start();
        if (CS_EN) begin
            send(16'h0010, 1'b0, 1'b1);
            send(16'h0020, 1'b0, 1'b1);
            send(16'h0030, 1'b0, 1'b1);
            send(16'h0060, 1'b1, 1'b1);
        end else begin
            send(16'h0C01, 1'b0, 1'b1);
            send(16'h0C02, 1'b0, 1'b1);
            send(16'h0C03, 1'b0, 1'b1);
            send(16'h0C04, 1'b1, 1'b1);
        end
        wait_run("reload");
        status("reload_run", 6'b001010, CS_EN ? 3 : 4, BOOT_RUN);
        repeat (2) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
